generations_cell: RTL and testbench
===================================

Name: generations_cell

Overview:
- Parametrised successor to the two-state Life cell: a single cellular-automaton cell implementing "Generations"-family rules with runtime-programmable birth/survive masks and 2..N states (alive, dead, and N-2 decaying "dying" states).
- Tiled into the 2D board array, one per cell. Neighbour alive bits come from adjacent cells' `alive` outputs; global `ena` advances one generation.
- Adds a `changed` flag for board-level stability detection.

Parameters:
- STATES, 2: number of cell states. Must be >= 2. 2 = classic Life. Each extra state adds one dying stage.
- SW, $clog2(STATES) (min 1): state encoding width. Derived; do not override.
- AGE_W, 8: width of the age counter. Used only with CELL_AGE_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset; loads initial state
- ena  input  1  generation advance strobe; one generation per cycle while high
- state_0  input  SW  initial state loaded on reset
- birth_mask  input  9  bit k=1: a dead cell with k live neighbours becomes alive
- survive_mask  input  9  bit k=1: a live cell with k live neighbours stays alive
- neighbors  input  8  alive bits of the 8 neighbours; order irrelevant
- state_d  output  SW  combinational next state
- state_q  output  SW  registered current state
- alive  output  1  combinational, (state_q == 1)
- changed  output  1  combinational, (state_d != state_q)
- age  output  AGE_W  consecutive generations alive; present only with CELL_AGE_EN

Behaviour:
- Encoding: 0 = dead, 1 = alive, 2..STATES-1 = dying stages. Only state 1 counts as a live neighbour.
- n = popcount(neighbors), range 0..8. Index masks with the 4-bit value n.
- Next-state function (state_d, purely combinational):
  - state_q == 0: state_d = birth_mask[n] ? 1 : 0.
  - state_q == 1: state_d = survive_mask[n] ? 1 : (STATES > 2 ? 2 : 0).
  - 2 <= state_q < STATES-1: state_d = state_q + 1. Neighbours are ignored.
  - state_q == STATES-1 (when STATES > 2): state_d = 0.
  - state_q >= STATES (unused encodings, possible when STATES is not a power of 2): state_d = 0.
- Register update, at posedge clk:
  - rst = 1: state_q <= (state_0 < STATES) ? state_0 : 0.
  - Else if ena = 1: state_q <= state_d.
  - Else: hold.
  - rst has priority over ena.
- Latency: a new state is visible on state_q one cycle after the ena edge. alive and changed follow state_q combinationally in the same cycle.
- Reset values: state_q = sanitised state_0; alive = (sanitised state_0 == 1); age = 0.
- Mid-run reset: takes effect on the next edge regardless of ena. No residual state is kept.
- Masks may change between generations. Changing them while ena = 1 applies to that same edge; no shadowing.
- No implicit latches. state_d is fully defined for every state_q and neighbours combination.

Optional Feature:
- Macro: CELL_AGE_EN.
- Defined: adds output age[AGE_W-1:0]. At each posedge clk:
  - rst: age <= 0.
  - Else if ena and state_q == 1 and state_d == 1: age <= age + 1, saturating at 2^AGE_W - 1.
  - Else if ena: age <= 0.
  - Else: hold.
  - A newly born cell therefore has age 0.
- Undefined: no age port, no counter logic. All other behaviour is identical.

Test Plan:
- Life rule: STATES=2, birth=9'h008, survive=9'h00C. Dead cell with neighbors=8'b0000_0111, ena=1 -> state_q=1 next cycle, changed=1 beforehand. Alive cell with 1 neighbour -> 0. Alive cell with 2 neighbours -> stays 1, changed=0.
- Decay chain: STATES=4, same masks. Alive cell with 0 neighbours -> sequence 1,2,3,0 over successive ena cycles. Neighbours set to 8'hFF during states 2/3 have no effect. Dead cell with 3 neighbours is born.
- Illegal state: STATES=3 (SW=2). Reset with state_0=3 -> state_q=0, alive=0. Also force-check that state_d=0 when state_q=3.
- Reset/ena priority: rst=1 and ena=1 together, with state_0=1 and a birth-inducing neighbourhood -> state_q=1 from state_0. With rst=0, ena=0 for 5 cycles -> state_q unchanged.
- Mask edges: birth=9'h100 with neighbors=8'hFF -> birth. survive=9'h001 with an alive cell and 0 neighbours -> survives. Masks changed between two ena pulses -> the second generation uses the new mask.
- CELL_AGE_EN, AGE_W=3: alive cell with survive=9'h1FF for 10 ena cycles -> age reads 1..7, then holds 7. Death -> age 0. Rebirth -> age 0, then increments.

Source files
------------

// File: rtl/generations_cell.sv
// Generations-family cellular-automaton cell: programmable birth/survive masks, STATES-2 dying stages.
// Optional consecutive-generations-alive counter enabled by defining CELL_AGE_EN.
module generations_cell #(
  parameter int STATES = 2,
  parameter int SW     = (STATES > 2) ? $clog2(STATES) : 1,
  parameter int AGE_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [SW-1:0] state_0,
  input  logic [8:0]    birth_mask,
  input  logic [8:0]    survive_mask,
  input  logic [7:0]    neighbors,
  output logic [SW-1:0] state_d,
  output logic [SW-1:0] state_q,
  output logic          alive,
  output logic          changed
`ifdef CELL_AGE_EN
  ,
  output logic [AGE_W-1:0] age
`endif
);

  // One past the highest legal encoding; SW+1 bits so it fits when STATES is a power of two.
  localparam logic [SW:0]   STATE_LIM = (SW + 1)'(STATES);
  localparam logic [SW-1:0] S_DEAD    = '0;
  localparam logic [SW-1:0] S_ALIVE   = SW'(1);
  localparam logic [SW-1:0] S_DYING0  = (STATES > 2) ? SW'(2) : S_DEAD;
  localparam logic [SW-1:0] S_LAST    = SW'(STATES - 1);

  if (STATES < 2) begin : g_bad_states
    $error("generations_cell: STATES must be >= 2");
  end
  if (AGE_W < 1) begin : g_bad_age_w
    $error("generations_cell: AGE_W must be >= 1");
  end

  logic [3:0] n_live;
  logic       state_legal;
  logic [SW-1:0] state_0_clean;

  always_comb begin
    n_live = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n_live = n_live + {3'b000, neighbors[i]};
    end
  end

  assign state_legal   = ({1'b0, state_q} < STATE_LIM);
  assign state_0_clean = ({1'b0, state_0} < STATE_LIM) ? state_0 : S_DEAD;

  always_comb begin
    // NOTE: default assigned first so every path defines state_d and no latch is inferred.
    state_d = S_DEAD;
    if (state_q == S_DEAD) begin
      state_d = birth_mask[n_live] ? S_ALIVE : S_DEAD;
    end else if (state_q == S_ALIVE) begin
      state_d = survive_mask[n_live] ? S_ALIVE : S_DYING0;
    end else if (state_legal && (state_q != S_LAST)) begin
      state_d = state_q + S_ALIVE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all registered state, so every cell samples its neighbours' old values.
    if (rst) begin
      state_q <= state_0_clean;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  assign alive   = (state_q == S_ALIVE);
  assign changed = (state_d != state_q);

`ifdef CELL_AGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if (ena) begin
      if (alive && (state_d == S_ALIVE)) begin
        if (age != {AGE_W{1'b1}}) age <= age + 1'b1;
      end else begin
        age <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_generations_cell.sv
// Directed bench for generations_cell: Life rule, decay chain, illegal encodings, reset priority, masks, age.
module tb_generations_cell;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // STATES=2 (classic Life)
  logic       rst2 = 1'b0, ena2 = 1'b0;
  logic [0:0] s0_2 = '0, sd2, sq2;
  logic [8:0] bm2 = 9'h008, sm2 = 9'h00C;
  logic [7:0] nb2 = '0;
  logic       al2, ch2;

  generations_cell #(.STATES(2)) u_c2 (
    .clk(clk), .rst(rst2), .ena(ena2), .state_0(s0_2), .birth_mask(bm2),
    .survive_mask(sm2), .neighbors(nb2), .state_d(sd2), .state_q(sq2),
    .alive(al2), .changed(ch2)
`ifdef CELL_AGE_EN
    , .age()
`endif
  );

  // STATES=4 (two dying stages)
  logic       rst4 = 1'b0, ena4 = 1'b0;
  logic [1:0] s0_4 = '0, sd4, sq4;
  logic [8:0] bm4 = 9'h008, sm4 = 9'h00C;
  logic [7:0] nb4 = '0;
  logic       al4, ch4;

  generations_cell #(.STATES(4)) u_c4 (
    .clk(clk), .rst(rst4), .ena(ena4), .state_0(s0_4), .birth_mask(bm4),
    .survive_mask(sm4), .neighbors(nb4), .state_d(sd4), .state_q(sq4),
    .alive(al4), .changed(ch4)
`ifdef CELL_AGE_EN
    , .age()
`endif
  );

  // STATES=3 (encoding 3 unused)
  logic       rst3 = 1'b0, ena3 = 1'b0;
  logic [1:0] s0_3 = '0, sd3, sq3;
  logic [8:0] bm3 = 9'h008, sm3 = 9'h00C;
  logic [7:0] nb3 = '0;
  logic       al3, ch3;

  generations_cell #(.STATES(3)) u_c3 (
    .clk(clk), .rst(rst3), .ena(ena3), .state_0(s0_3), .birth_mask(bm3),
    .survive_mask(sm3), .neighbors(nb3), .state_d(sd3), .state_q(sq3),
    .alive(al3), .changed(ch3)
`ifdef CELL_AGE_EN
    , .age()
`endif
  );

`ifdef CELL_AGE_EN
  logic       rsta = 1'b0, enaa = 1'b0;
  logic [0:0] s0_a = '0, sda, sqa;
  logic [8:0] bma = 9'h008, sma = 9'h1FF;
  logic [7:0] nba = '0;
  logic       ala, cha;
  logic [2:0] agea;

  generations_cell #(.STATES(2), .AGE_W(3)) u_ca (
    .clk(clk), .rst(rsta), .ena(enaa), .state_0(s0_a), .birth_mask(bma),
    .survive_mask(sma), .neighbors(nba), .state_d(sda), .state_q(sqa),
    .alive(ala), .changed(cha), .age(agea)
  );
`endif

  initial begin
    // ---------------- Life rule ----------------
    rst2 = 1'b1; s0_2 = 1'b0; tick(); rst2 = 1'b0;
    check("life_rst_q", sq2, 0);
    check("life_rst_alive", al2, 0);
    nb2 = 8'b0000_0111; ena2 = 1'b1; #1;
    check("life_birth_d", sd2, 1);
    check("life_birth_changed", ch2, 1);
    tick();
    check("life_birth_q", sq2, 1);
    check("life_birth_alive", al2, 1);
    nb2 = 8'h01; #1;
    check("life_lonely_d", sd2, 0);
    tick();
    check("life_lonely_q", sq2, 0);
    rst2 = 1'b1; s0_2 = 1'b1; ena2 = 1'b0; tick(); rst2 = 1'b0;
    nb2 = 8'h03; ena2 = 1'b1; #1;
    check("life_survive_changed", ch2, 0);
    tick();
    check("life_survive_q", sq2, 1);

    // ---------------- Reset / enable priority ----------------
    rst2 = 1'b1; s0_2 = 1'b0; ena2 = 1'b0; tick();
    nb2 = 8'b0000_0111; s0_2 = 1'b0; ena2 = 1'b1; tick();
    check("prio_rst0_over_birth", sq2, 0);
    s0_2 = 1'b1; tick();
    check("prio_rst1", sq2, 1);
    rst2 = 1'b0; ena2 = 1'b0; nb2 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_no_ena", sq2, 1);
    end

    // ---------------- Mask edges ----------------
    rst2 = 1'b1; s0_2 = 1'b0; tick(); rst2 = 1'b0;
    bm2 = 9'h100; nb2 = 8'hFF; ena2 = 1'b1; tick();
    check("mask_birth8", sq2, 1);
    sm2 = 9'h001; nb2 = 8'h00; tick();
    check("mask_survive0", sq2, 1);
    ena2 = 1'b0; sm2 = 9'h00C; tick();
    ena2 = 1'b1; tick();
    check("mask_changed_between", sq2, 0);

    // ---------------- Decay chain ----------------
    rst4 = 1'b1; s0_4 = 2'd1; tick(); rst4 = 1'b0;
    check("decay_rst_q", sq4, 1);
    nb4 = 8'h00; ena4 = 1'b1; tick();
    check("decay_q2", sq4, 2);
    check("decay_q2_alive", al4, 0);
    nb4 = 8'hFF; #1;
    check("decay_q2_d", sd4, 3);
    tick();
    check("decay_q3", sq4, 3);
    tick();
    check("decay_q0", sq4, 0);
    nb4 = 8'b0001_0101; tick();
    check("decay_reborn", sq4, 1);
    ena4 = 1'b0;

    // ---------------- Illegal encoding ----------------
    rst3 = 1'b1; s0_3 = 2'd3; tick();
    check("ill_rst_q", sq3, 0);
    check("ill_rst_alive", al3, 0);
    s0_3 = 2'd2; tick(); rst3 = 1'b0;
    check("ill_rst2_q", sq3, 2);
    ena3 = 1'b1; nb3 = 8'hFF; tick();
    check("ill_last_to_dead", sq3, 0);
    ena3 = 1'b0;
    force u_c3.state_q = 2'd3;
    #1;
    check("ill_force_d", sd3, 0);
    check("ill_force_changed", ch3, 1);
    release u_c3.state_q;
    rst3 = 1'b1; s0_3 = 2'd0; tick(); rst3 = 1'b0;
    check("ill_recover", sq3, 0);

`ifdef CELL_AGE_EN
    // ---------------- Age counter ----------------
    rsta = 1'b1; s0_a = 1'b1; tick(); rsta = 1'b0;
    check("age_rst", agea, 0);
    enaa = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("age_count", agea, (i > 7) ? 7 : i);
    end
    sma = 9'h000; tick();
    check("age_death_q", sqa, 0);
    check("age_death", agea, 0);
    nba = 8'b0000_0111; tick();
    check("age_reborn_q", sqa, 1);
    check("age_reborn", agea, 0);
    sma = 9'h1FF; tick();
    check("age_reborn_inc", agea, 1);
    enaa = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
